// File: rtl/bconv_pkg.sv
// Shared types and field layout for the multi-kernel binary convolution engine.
// Covers the FSM states, header and kernel-word bit fields, and kernel-count clamping.
package bconv_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadW = 3'd1,
    StHdr   = 3'd2,
    StFill  = 3'd3,
    StOut   = 3'd4,
    StDone  = 3'd5
  } bconv_state_e;

  localparam int unsigned HdrDimLsb   = 0;
  localparam int unsigned HdrDimW     = 5;
  localparam logic [15:0] HdrSentinel = 16'h00FF;

  localparam int unsigned WgtLsb = 0;
  localparam int unsigned WgtW   = 9;
  localparam int unsigned ThrLsb = 9;
  localparam int unsigned ThrW   = 4;
  localparam int unsigned KcntW  = 4;

  // A count of zero still runs one kernel; anything above capacity is cut to capacity.
  function automatic logic [KcntW-1:0] clamp_kcount(input logic [KcntW-1:0] raw,
                                                    input logic [KcntW-1:0] max_k);
    logic [KcntW-1:0] k;
    k = raw;
    if (raw == '0) begin
      k = KcntW'(1);
    end else if (raw > max_k) begin
      k = max_k;
    end
    return k;
  endfunction

endpackage

// File: rtl/bconv_pe.sv
// One output pixel: XNOR the 3x3 window against the weights, popcount the matches,
// and compare the count with the kernel threshold.
module bconv_pe
  import bconv_pkg::*;
(
  input  logic [WgtW-1:0] weight,
  input  logic [WgtW-1:0] window,
  input  logic [ThrW-1:0] thresh,
  output logic            hit
);

  logic [WgtW-1:0] match;
  logic [3:0]      cnt;

  always_comb begin
    match = ~(weight ^ window);
    cnt   = '0;
    for (int i = 0; i < int'(WgtW); i++) begin
      cnt = cnt + {3'b000, match[i]};
    end
    hit = (cnt >= thresh);
  end

endmodule

// File: rtl/bconv_multi_kernel.sv
// Streams binary images from SRAM, runs every loaded kernel over each image and writes one
// feature map per kernel, until a terminating header is read.
module bconv_multi_kernel
  import bconv_pkg::*;
#(
  parameter int unsigned MAX_DIM     = 16,
  parameter int unsigned NUM_KERNELS = 4,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [15:0]       sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [15:0]       dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [15:0]       wmem_dut_read_data
);

  localparam int unsigned NumPe = MAX_DIM - 2;
  localparam int unsigned CntW  = 5;

  bconv_state_e state_q, state_d;
  logic [ADDR_W-1:0] wa_q, wa_d, sa_q, sa_d, base_q, base_d, next_base;
  logic [ADDR_W-1:0] wptr_q, wptr_d, wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d, out_word;
  logic              wr_en_q, wr_en_d;
  logic              iss_q, iss_d, vld_q;
  logic              row_ready_q, row_ready_d;
  logic [CntW-1:0]   n_iss_q, n_iss_d, n_rcv_q, n_rcv_d, out_row_q, out_row_d;
  logic [KcntW-1:0]  kcount_q, kcount_d, kidx_q, kidx_d, k_now, k_lim;
  logic [4:0]        dim_q, dim_d, hdr_dim;
  logic [MAX_DIM-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [WgtW-1:0]   kw_q [NUM_KERNELS];
  logic [ThrW-1:0]   kt_q [NUM_KERNELS];
  logic [WgtW-1:0]   cur_w;
  logic [ThrW-1:0]   cur_t;
  logic [NumPe-1:0]  pe_hit;
  logic              unused_wmem;

  assign unused_wmem = ^wmem_dut_read_data[15:ThrLsb+ThrW];
  assign k_now       = clamp_kcount(wmem_dut_read_data[KcntW-1:0], KcntW'(NUM_KERNELS));
  assign hdr_dim     = sram_dut_read_data[HdrDimLsb +: HdrDimW];
  assign next_base   = base_q + ADDR_W'(dim_q) + ADDR_W'(1);

  assign dut_busy               = (state_q != StIdle) && (state_q != StDone);
  assign dut_sram_read_address  = sa_q;
  assign dut_wmem_read_address  = wa_q;
  assign dut_sram_write_address = wr_addr_q;
  assign dut_sram_write_data    = wr_data_q;
  assign dut_sram_write_enable  = wr_en_q;

  always_comb begin
    cur_w = '0;
    cur_t = '0;
    for (int i = 0; i < int'(NUM_KERNELS); i++) begin
      if (kidx_q == KcntW'(i)) begin
        cur_w = kw_q[i];
        cur_t = kt_q[i];
      end
    end
  end

  for (genvar c = 0; c < int'(NumPe); c++) begin : g_pe
    bconv_pe u_pe (
      .weight (cur_w),
      .window ({bot_q[c +: 3], mid_q[c +: 3], top_q[c +: 3]}),
      .thresh (cur_t),
      .hit    (pe_hit[c])
    );
  end

  // Columns beyond dim-3 see bits outside the image and are forced to zero.
  always_comb begin
    out_word = '0;
    for (int c = 0; c < int'(NumPe); c++) begin
      if (5'(c + 3) <= dim_q) begin
        out_word[c] = pe_hit[c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wa_d        = wa_q;
    sa_d        = sa_q;
    base_d      = base_q;
    wptr_d      = wptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    iss_d       = 1'b0;
    row_ready_d = 1'b0;
    n_iss_d     = n_iss_q;
    n_rcv_d     = n_rcv_q;
    out_row_d   = out_row_q;
    kcount_d    = kcount_q;
    kidx_d      = kidx_q;
    dim_d       = dim_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    // Until word 0 arrives only address 1 is known to be needed (K is at least 1).
    k_lim = kcount_q;
    if (n_rcv_q == '0) k_lim = vld_q ? k_now : KcntW'(1);

    unique case (state_q)
      StIdle: begin
        if (dut_run) begin
          state_d = StLoadW;
          wa_d    = '0;
          iss_d   = 1'b1;
          n_iss_d = CntW'(1);
          n_rcv_d = '0;
          base_d  = '0;
          wptr_d  = '0;
        end
      end
      StLoadW: begin
        if (n_iss_q <= CntW'(k_lim)) begin
          wa_d    = wa_q + ADDR_W'(1);
          iss_d   = 1'b1;
          n_iss_d = n_iss_q + CntW'(1);
        end
        if (vld_q) begin
          n_rcv_d = n_rcv_q + CntW'(1);
          if (n_rcv_q == '0) kcount_d = k_now;
          if (n_rcv_q == CntW'(k_lim)) begin
            state_d = StHdr;
            sa_d    = base_q;
            iss_d   = 1'b1;
          end
        end
      end
      StHdr: begin
        if (vld_q) begin
          if (sram_dut_read_data == HdrSentinel || hdr_dim < 5'd3 ||
              hdr_dim > 5'(MAX_DIM)) begin
            state_d = StDone;
          end else begin
            state_d   = StFill;
            dim_d     = hdr_dim;
            kidx_d    = '0;
            sa_d      = base_q + ADDR_W'(1);
            iss_d     = 1'b1;
            n_iss_d   = CntW'(1);
            n_rcv_d   = '0;
            out_row_d = '0;
          end
        end
      end
      StFill, StOut: begin
        if (n_iss_q < dim_q) begin
          sa_d    = sa_q + ADDR_W'(1);
          iss_d   = 1'b1;
          n_iss_d = n_iss_q + CntW'(1);
        end
        if (vld_q) begin
          top_d   = mid_q;
          mid_d   = bot_q;
          bot_d   = sram_dut_read_data[MAX_DIM-1:0];
          n_rcv_d = n_rcv_q + CntW'(1);
          if (n_rcv_q >= CntW'(2)) row_ready_d = 1'b1;
          if (state_q == StFill && n_rcv_q == CntW'(2)) state_d = StOut;
        end
        if (state_q == StOut && row_ready_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wptr_q;
          wr_data_d = out_word;
          wptr_d    = wptr_q + ADDR_W'(1);
        end
        // Leave only once the last word's strobe is on the port, so it stays inside OUT.
        if (state_q == StOut && wr_en_q) begin
          out_row_d = out_row_q + CntW'(1);
          if (out_row_q == dim_q - 5'd3) begin
            iss_d = 1'b1;
            if (kidx_q == kcount_q - KcntW'(1)) begin
              state_d = StHdr;
              base_d  = next_base;
              sa_d    = next_base;
            end else begin
              state_d   = StFill;
              kidx_d    = kidx_q + KcntW'(1);
              sa_d      = base_q + ADDR_W'(1);
              n_iss_d   = CntW'(1);
              n_rcv_d   = '0;
              out_row_d = '0;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= StIdle;
      wa_q        <= '0;
      sa_q        <= '0;
      base_q      <= '0;
      wptr_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      iss_q       <= 1'b0;
      vld_q       <= 1'b0;
      row_ready_q <= 1'b0;
      n_iss_q     <= '0;
      n_rcv_q     <= '0;
      out_row_q   <= '0;
      kcount_q    <= '0;
      kidx_q      <= '0;
      dim_q       <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
    end else begin
      state_q     <= state_d;
      wa_q        <= wa_d;
      sa_q        <= sa_d;
      base_q      <= base_d;
      wptr_q      <= wptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      iss_q       <= iss_d;
      vld_q       <= iss_q;
      row_ready_q <= row_ready_d;
      n_iss_q     <= n_iss_d;
      n_rcv_q     <= n_rcv_d;
      out_row_q   <= out_row_d;
      kcount_q    <= kcount_d;
      kidx_q      <= kidx_d;
      dim_q       <= dim_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < int'(NUM_KERNELS); i++) begin
        kw_q[i] <= '0;
        kt_q[i] <= '0;
      end
    end else if (state_q == StLoadW && vld_q && n_rcv_q != '0) begin
      for (int i = 0; i < int'(NUM_KERNELS); i++) begin
        if (n_rcv_q == CntW'(i + 1)) begin
          kw_q[i] <= wmem_dut_read_data[WgtLsb +: WgtW];
          kt_q[i] <= wmem_dut_read_data[ThrLsb +: ThrW];
        end
      end
    end
  end

endmodule

// File: tb/tb_bconv_multi_kernel.sv
// Self-checking bench: directed scenarios plus randomized runs scored against a
// behavioural model that evaluates the convolution rules directly on the memory images.
module tb_bconv_multi_kernel;

  localparam int MaxDim = 16;
  localparam int NumK   = 4;
  localparam int AddrW  = 12;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              dut_run = 1'b0;
  logic              dut_busy;
  logic [AddrW-1:0]  sram_raddr, waddr, wmem_raddr;
  logic [15:0]       sram_rdata = '0, wmem_rdata = '0, wdata;
  logic              we;

  logic [15:0] sram [0:4095];
  logic [15:0] wmem [0:4095];
  logic [AddrW-1:0] got_addr [$];
  logic [15:0]      got_data [$];
  logic [15:0]      exp_data [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bconv_multi_kernel #(.MAX_DIM(MaxDim), .NUM_KERNELS(NumK), .ADDR_W(AddrW)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (sram_raddr),
    .sram_dut_read_data     (sram_rdata),
    .dut_sram_write_address (waddr),
    .dut_sram_write_data    (wdata),
    .dut_sram_write_enable  (we),
    .dut_wmem_read_address  (wmem_raddr),
    .wmem_dut_read_data     (wmem_rdata)
  );

  always @(posedge clk) begin
    sram_rdata <= sram[sram_raddr];
    wmem_rdata <= wmem[wmem_raddr];
  end

  always @(negedge clk) begin
    if (reset_b && we) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      sram[i] = '0;
      wmem[i] = '0;
    end
  endtask

  task automatic put_image(input int base, input int dim, input int kind);
    logic [15:0] mask, row;
    mask = 16'((32'h1 << dim) - 1);
    sram[base] = 16'(dim);
    for (int r = 0; r < dim; r++) begin
      case (kind)
        0:       row = 16'hFFFF & mask;
        1:       row = (((r % 2) == 0) ? 16'h5555 : 16'hAAAA) & mask;
        2:       row = 16'h0000;
        default: row = 16'($urandom);
      endcase
      sram[base + 1 + r] = row;
    end
  endtask

  // Reference: evaluate each output pixel from the rules, image by image, kernel by kernel.
  task automatic build_expected();
    int k, base, dim, cnt;
    logic [15:0] hdr, w, word, prow;
    exp_data.delete();
    k = int'(wmem[0][3:0]);
    if (k == 0) k = 1;
    if (k > NumK) k = NumK;
    base = 0;
    for (int img = 0; img < 64; img++) begin
      hdr = sram[base];
      dim = int'(hdr[4:0]);
      if (hdr == 16'h00FF || dim < 3 || dim > MaxDim) break;
      for (int kk = 0; kk < k; kk++) begin
        w = wmem[1 + kk];
        for (int r = 0; r < dim - 2; r++) begin
          word = '0;
          for (int c = 0; c < dim - 2; c++) begin
            cnt = 0;
            for (int dr = 0; dr < 3; dr++) begin
              prow = sram[base + 1 + r + dr];
              for (int dc = 0; dc < 3; dc++) begin
                if (w[dr * 3 + dc] == prow[c + dc]) cnt++;
              end
            end
            if (cnt >= int'(w[12:9])) word[c] = 1'b1;
          end
          exp_data.push_back(word);
        end
      end
      base += dim + 1;
    end
  endtask

  task automatic run_dut(input bit poke, output int bc, output bit to);
    got_addr.delete();
    got_data.delete();
    bc = 0;
    to = 1'b1;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!dut_busy) begin
        to = 1'b0;
        break;
      end
      bc++;
      dut_run = poke && (bc == 4);
      @(negedge clk);
    end
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dut_busy, we, waddr, wdata, sram_raddr, wmem_raddr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {dut_busy, we, waddr, wdata, sram_raddr, wmem_raddr});
    end
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd1;
    wmem[1] = {3'b000, 4'd5, 9'h1FF};
    put_image(0, 10, 0);
    sram[11] = 16'h00FF;
    exp_data.delete();
    for (int i = 0; i < 8; i++) exp_data.push_back(16'h00FF);
    run_dut(1'b0, bc, to);
    checks++;
    if (to || got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL all_ones writes=%0d timeout=%0d want writes=%0d", got_data.size(), to,
               exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL all_ones word %0d addr=%0d data=%h want addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_checkerboard();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd2;
    wmem[1] = {3'b000, 4'd5, 9'h1FF};
    wmem[2] = {3'b000, 4'd5, 9'h000};
    put_image(0, 16, 1);
    sram[17] = 16'h00FF;
    build_expected();
    run_dut(1'b0, bc, to);
    checks++;
    if (to || got_data.size() != 28) begin
      failures++;
      $display("FAIL checker writes=%0d timeout=%0d want writes=28", got_data.size(), to);
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL checker word %0d addr=%0d data=%h want addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_thresholds_dim3();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd3;
    wmem[1] = {3'b000, 4'd0, 9'h000};
    wmem[2] = {3'b000, 4'd9, 9'h000};
    wmem[3] = {3'b000, 4'd10, 9'h000};
    put_image(0, 3, 2);
    sram[4] = 16'h00FF;
    exp_data.delete();
    exp_data.push_back(16'h0001);
    exp_data.push_back(16'h0001);
    exp_data.push_back(16'h0000);
    run_dut(1'b0, bc, to);
    checks++;
    if (to || got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL thr_dim3 writes=%0d timeout=%0d want writes=%0d", got_data.size(), to,
               exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL thr_dim3 word %0d addr=%0d data=%h want addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_two_images();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd1;
    wmem[1] = {3'b000, 4'($urandom_range(3, 7)), 9'($urandom)};
    put_image(0, 12, 3);
    put_image(13, 5, 3);
    sram[19] = 16'h00FF;
    build_expected();
    run_dut(1'b1, bc, to);
    checks++;
    if (to || got_data.size() != 13) begin
      failures++;
      $display("FAIL two_images writes=%0d timeout=%0d want writes=13", got_data.size(), to);
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL two_images word %0d addr=%0d data=%h want addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_early_sentinel();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd2;
    wmem[1] = {3'b000, 4'd1, 9'h0F0};
    wmem[2] = {3'b000, 4'd2, 9'h00F};
    sram[0] = 16'h0002;
    run_dut(1'b0, bc, to);
    checks++;
    if (to || got_data.size() != 0) begin
      failures++;
      $display("FAIL early_sentinel writes=%0d timeout=%0d want writes=0", got_data.size(), to);
    end
    checks++;
    if (bc >= 2 + 5) begin
      failures++;
      $display("FAIL early_sentinel busy_cycles=%0d want <%0d", bc, 2 + 5);
    end
  endtask

  task automatic test_reset_mid_run();
    int bc; bit to;
    clear_mem();
    wmem[0] = 16'd2;
    wmem[1] = {3'b000, 4'd4, 9'($urandom)};
    wmem[2] = {3'b000, 4'd6, 9'($urandom)};
    put_image(0, 10, 3);
    sram[11] = 16'h00FF;
    build_expected();
    got_addr.delete();
    got_data.delete();
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    for (int i = 0; i < 2000 && got_data.size() < 3; i++) @(negedge clk);
    checks++;
    if (got_data.size() < 3) begin
      failures++;
      $display("FAIL reset_mid writes_before_reset=%0d want >=3", got_data.size());
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if ({dut_busy, we, waddr, wdata, sram_raddr, wmem_raddr} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h want=0",
               {dut_busy, we, waddr, wdata, sram_raddr, wmem_raddr});
    end
    @(negedge clk) reset_b = 1'b1;
    @(negedge clk);
    run_dut(1'b0, bc, to);
    checks++;
    if (to || got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL reset_mid writes=%0d timeout=%0d want writes=%0d", got_data.size(), to,
               exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL reset_mid word %0d addr=%0d data=%h want addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    int bc, base, nimg, dim; bit to;
    for (int it = 0; it < 4; it++) begin
      clear_mem();
      wmem[0] = 16'($urandom_range(0, 7));
      for (int k = 1; k <= 8; k++) begin
        wmem[k] = {3'($urandom), 4'($urandom_range(0, 15)), 9'($urandom)};
      end
      base = 0;
      nimg = $urandom_range(1, 3);
      for (int n = 0; n < nimg; n++) begin
        dim = $urandom_range(3, MaxDim);
        put_image(base, dim, 3);
        base += dim + 1;
      end
      sram[base] = (it % 2 == 0) ? 16'h00FF : 16'h0011;
      build_expected();
      run_dut(1'b1, bc, to);
      checks++;
      if (to || got_data.size() != exp_data.size()) begin
        failures++;
        $display("FAIL random%0d writes=%0d timeout=%0d want writes=%0d", it, got_data.size(),
                 to, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
        checks++;
        if (got_addr[i] !== AddrW'(i) || got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL random%0d word %0d addr=%0d data=%h want addr=%0d data=%h", it, i,
                   got_addr[i], got_data[i], i, exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_all_ones();
    test_checkerboard();
    test_thresholds_dim3();
    test_two_images();
    test_early_sentinel();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
